// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO block: output data/direction registers, synchronised pin inputs,
// and edge capture with a masked level interrupt. Capture stays off until the synchroniser has filled.
module mmio_gpio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ARM_MAX      = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] data_out, dir, irq_mask, edge_cap;
  logic [WIDTH-1:0] sync_in, prev, edge_det, wd, cap_clr, rd_bits;
  logic [2:0]       arm_cnt;
  logic             armed, bus_wr;

  function automatic logic [2:0] arm_inc(input logic [2:0] cnt);
    return (cnt == ARM_MAX) ? cnt : cnt + 3'd1;
  endfunction

  function automatic logic [WIDTH-1:0] detect_edge(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] old);
    case (EDGE_TYPE)
      0:       return cur & ~old;
      1:       return ~cur & old;
      default: return cur ^ old;
    endcase
  endfunction

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign wd       = writedata[WIDTH-1:0];
  assign bus_wr   = chipselect & ~write_n;
  assign armed    = (arm_cnt == ARM_MAX);
  assign edge_det = detect_edge(sync_in, prev);
  assign cap_clr  = (bus_wr && address == ADDR_EDGECAP) ? wd : '0;

  // Synchroniser, edge history and arming counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev    <= sync_in;
      arm_cnt <= arm_inc(arm_cnt);
    end
  end

  // Bus-visible registers; a capture set beats a same-cycle W1C clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | (edge_det & {WIDTH{armed}});
      if (bus_wr) begin
        case (address)
          ADDR_DATA:    data_out <= wd;
          ADDR_DIR:     dir      <= wd;
          ADDR_IRQMASK: irq_mask <= wd;
          ADDR_OUTSET:  data_out <= data_out | wd;
          ADDR_OUTCLR:  data_out <= data_out & ~wd;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    rd_bits = '0;
    case (address)
      ADDR_DATA:    rd_bits = (data_out & dir) | (sync_in & ~dir);
      ADDR_DIR:     rd_bits = dir;
      ADDR_IRQMASK: rd_bits = irq_mask;
      ADDR_EDGECAP: rd_bits = edge_cap;
      default:      rd_bits = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_bits;
  end

  assign out_port = data_out;
  assign oe       = dir;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_mmio_gpio.sv
// Bench for mmio_gpio: a pin-history model checked every cycle, plus directed
// register-level scenarios with literal expectations.
module tb_mmio_gpio;

  localparam int         W  = 8;
  localparam int         S  = 2;
  localparam int         ET = 0;
  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  in_port = 8'h00;
  logic [7:0]  out_port, oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_gpio #(.WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(ET), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: pin samples history m_pin[0] = newest; the synchronised view is the
  // sample taken S-1 edges before the newest, its predecessor is one older.
  logic [7:0] m_data, m_dir, m_mask, m_cap;
  logic [7:0] m_pin [0:S];
  int         m_cyc;
  logic [7:0] m_sync, m_prev, m_edge, wd;
  logic       bus_wr;

  assign m_sync = m_pin[S-1];
  assign m_prev = m_pin[S];
  assign m_edge = (ET == 0) ? (m_sync & ~m_prev) :
                  (ET == 1) ? (~m_sync & m_prev) : (m_sync ^ m_prev);
  assign wd     = writedata[7:0];
  assign bus_wr = chipselect & ~write_n;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= RV;
      m_dir  <= 8'h00;
      m_mask <= 8'h00;
      m_cap  <= 8'h00;
      m_cyc  <= 0;
      for (int i = 0; i <= S; i++) m_pin[i] <= 8'h00;
    end else begin
      if (bus_wr) begin
        case (address)
          3'd0: m_data <= wd;
          3'd1: m_dir  <= wd;
          3'd2: m_mask <= wd;
          3'd4: m_data <= m_data | wd;
          3'd5: m_data <= m_data & ~wd;
          default: ;
        endcase
      end
      m_cap <= (m_cap & ~((bus_wr && address == 3'd3) ? wd : 8'h00)) |
               ((m_cyc >= S + 1) ? m_edge : 8'h00);
      m_cyc <= (m_cyc > 100) ? m_cyc : m_cyc + 1;
      for (int i = 1; i <= S; i++) m_pin[i] <= m_pin[i-1];
      m_pin[0] <= in_port;
    end
  end

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {24'd0, (m_data & m_dir) | (m_sync & ~m_dir)};
      3'd1:    return {24'd0, m_dir};
      3'd2:    return {24'd0, m_mask};
      3'd3:    return {24'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("mdl_out_port", 32'(out_port), 32'(m_data));
    chk("mdl_oe", 32'(oe), 32'(m_dir));
    chk("mdl_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    chk("mdl_readdata", readdata, m_rd(address));
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    idle(3);
    chk("rst_out_port", 32'(out_port), 32'h A5);
    chk("rst_oe", 32'(oe), 32'h00);
    chk("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    rd(3'd1, "rst_dir", 32'h0);
    rd(3'd2, "rst_irqmask", 32'h0);
    rd(3'd3, "rst_edgecap", 32'h0);
    idle(5);

    wr(3'd0, 32'h3C); chk("data_3c", 32'(out_port), 32'h3C);
    wr(3'd4, 32'h01); chk("outset_3d", 32'(out_port), 32'h3D);
    wr(3'd5, 32'h0C); chk("outclr_31", 32'(out_port), 32'h31);
    rd(3'd4, "outset_rd0", 32'h0);
    rd(3'd5, "outclr_rd0", 32'h0);

    wr(3'd1, 32'h0F);
    wr(3'd0, 32'hFFFF_FFFF); chk("data_ff", 32'(out_port), 32'hFF);
    chk("oe_0f", 32'(oe), 32'h0F);
    in_port = 8'hA0;
    idle(3);
    rd(3'd0, "data_mixed_af", 32'hAF);
    rd(3'd3, "cap_a0", 32'hA0);
    wr(3'd3, 32'hFF); rd(3'd3, "cap_w1c_all", 32'h0);

    wr(3'd2, 32'h01);
    in_port = 8'hA1;
    idle(S + 2);
    rd(3'd3, "cap_rise_b0", 32'h01);
    chk("irq_set", 32'(irq), 32'h1);
    wr(3'd3, 32'h01);
    chk("irq_cleared", 32'(irq), 32'h0);
    in_port = 8'hA0;
    idle(4);
    rd(3'd3, "cap_fall_ignored", 32'h0);
    in_port = 8'hA1;
    @(posedge clk);
    wr(3'd3, 32'h01);
    rd(3'd3, "cap_set_wins", 32'h01);
    chk("irq_set_wins", 32'(irq), 32'h1);

    in_port = 8'h00;
    idle(4);
    in_port = 8'hFF;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_port), 32'hA5);
    chk("async_rst_oe", 32'(oe), 32'h00);
    chk("async_rst_irq", 32'(irq), 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    rd(3'd3, "arm_no_capture", 32'h0);
    rd(3'd0, "data_in_ff", 32'hFF);
    in_port = 8'hF7;
    idle(4);
    in_port = 8'hFF;
    idle(4);
    rd(3'd3, "cap_bit3", 32'h08);

    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    chk("addr6_out", 32'(out_port), 32'hA5);
    chk("addr6_oe", 32'(oe), 32'h00);
    rd(3'd2, "addr6_mask", 32'h0);
    rd(3'd3, "addr6_cap", 32'h08);
    rd(3'd6, "addr6_rd0", 32'h0);

    @(posedge clk); #1;
    address = 3'd0; writedata = 32'h00; chipselect = 1'b0; write_n = 1'b0;
    @(posedge clk); #1;
    write_n = 1'b1; chipselect = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    chk("no_cs_no_write", 32'(out_port), 32'hA5);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_gpio.md
MMIO_GPIO -- requirements
Module: mmio_gpio

Interface
REQ-001 Parameter WIDTH, default 8: number of GPIO bits, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: reset value of the output data register (WIDTH bits).
REQ-003 Parameter EDGE_TYPE, default 0: edge to capture; 0 = rising, 1 = falling, 2 = any.
REQ-004 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-005 Port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port address, input, 3 bits: word register select.
REQ-008 Port chipselect, input, 1 bit: slave select.
REQ-009 Port write_n, input, 1 bit: active-low write strobe.
REQ-010 Port writedata, input, 32 bits: write data.
REQ-011 Port readdata, output, 32 bits: combinational read data for the current address.
REQ-012 Port in_port, input, WIDTH bits: asynchronous pin inputs.
REQ-013 Port out_port, output, WIDTH bits: output data register value.
REQ-014 Port oe, output, WIDTH bits: per-bit output enable, equal to the direction register.
REQ-015 Port irq, output, 1 bit: level interrupt.

Function
REQ-016 A write occurs on a clock edge when chipselect=1 and write_n=0; at any other time no register changes due to the bus.
REQ-017 The register map SHALL be: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR; addresses 6-7 read 0 and ignore writes.
REQ-018 DATA write: data_out <= writedata[WIDTH-1:0]. DATA read: bit i = data_out[i] if DIR[i]=1, else sync_in[i].
REQ-019 DIR: read/write, 1 = output; oe = DIR.
REQ-020 IRQMASK: read/write; irq = |(EDGECAP & IRQMASK), combinational from registers, with no additional latency.
REQ-021 EDGECAP: read returns the capture bits; writing 1 clears a bit (W1C); writing 0 has no effect.
REQ-022 OUTSET write: data_out <= data_out | wd. OUTCLR write: data_out <= data_out & ~wd. Both read as 0.
REQ-023 readdata[31:WIDTH] SHALL be 0; writedata[31:WIDTH] is ignored.
REQ-024 in_port passes through a SYNC_STAGES flop chain to give sync_in; a pin change is visible in a DATA read SYNC_STAGES cycles after it is sampled.
REQ-025 A prev register holds sync_in delayed 1 cycle; edge[i] is derived per EDGE_TYPE (rise = sync&~prev, fall = ~sync&prev, any = sync^prev).
REQ-026 When edge[i]=1 and capture is armed, EDGECAP[i] is set on the next clock edge; the set is independent of DIR and IRQMASK.
REQ-027 If an edge set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-028 An arm counter of SYNC_STAGES+1 cycles starts after reset release; capture is disarmed until the counter saturates, so no spurious edges are captured from the pipe fill.
REQ-029 A captured bit holds until cleared; further edges on that bit have no additional effect.

Reset
REQ-030 While reset_n=0: data_out=RESET_VALUE, DIR=0, IRQMASK=0, EDGECAP=0, sync chain=0, prev=0, arm counter=0; hence oe=0, irq=0 and out_port=RESET_VALUE.
REQ-031 Assertion of reset_n mid-operation SHALL take effect immediately (asynchronously) and discard pending captures.

Verification
REQ-032 Reset with RESET_VALUE=8'hA5 -> out_port=A5, oe=00, irq=0; reads of DIR, IRQMASK and EDGECAP return 0.
REQ-033 Write DATA=3C, then OUTSET=01, then OUTCLR=0C -> out_port=3C, then 3D, then 31; reads of OUTSET and OUTCLR return 0.
REQ-034 DIR=0F, data_out=FF, in_port=A0 settled for 3 cycles -> DATA read returns AF.
REQ-035 EDGE_TYPE=0, IRQMASK=01, in_port[0] 0->1 -> EDGECAP=01 by cycle SYNC_STAGES+2 and irq=1; W1C 01 -> irq=0; W1C coincident with a new edge -> bit stays 1.
REQ-036 in_port=FF held through reset release -> EDGECAP remains 00 (arming check); a subsequent 1->0->1 toggle on bit 3 -> EDGECAP=08.
REQ-037 Writes to address 6 with data FFFFFFFF -> no register changes, and the read of address 6 returns 0.
